pe_ingress_scheduler: RTL
=========================

Name: pe_ingress_scheduler

Overview:
Clocked packet scheduler in front of one processing_unit input. It shares the PE's single 32-bit ingress between NREQ packet sources (data generators or router ports) using round-robin arbitration, with the grant held for a whole packet. Packets whose header destination does not match PE_ADDR are consumed and counted, and are never forwarded. It sequences header-then-payload delivery so that a PE never sees interleaved packets.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, data word width
PE_ADDR, 3'b001, address of the attached PE
DROP_CW, 16, width of the dropped-packet counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-source word valid
req_data  in  NREQ*WIDTH  per-source word; source i occupies bits [i*WIDTH +: WIDTH]
req_ready  out  NREQ  per-source accept
pe_valid  out  1  word valid toward PE
pe_data  out  WIDTH  word toward PE
pe_last  out  1  marks the final word of a packet
pe_ready  in  1  PE accept
grant  out  NREQ  one-hot current owner; 0 when idle
busy  out  1  a packet is in progress
drop_cnt  out  DROP_CW  count of dropped packets, saturating

Behaviour:
- Transfer rule: a word transfers on a rising edge where valid and ready are both 1 on that link. Valid must not depend combinationally on ready.
- Header fields: [31:29] dest, [28:26] src, [25:24] type, [15:8] LEN = number of payload words (0..255). All other bits are reserved and passed through unchanged.
- Reset, asynchronous and active-low:
  - state=IDLE, rr_ptr=0, grant=0, busy=0.
  - pe_valid=0, pe_last=0, req_ready=0, drop_cnt=0.
  - pe_data=0 while pe_valid=0.
- State IDLE:
  - All req_ready=0.
  - If any req_valid is 1, pick the first valid source at or after rr_ptr, searching upward modulo NREQ. Register it in grant.
  - Next state is HDR. Arbitration latency is 1 cycle.
- State HDR:
  - Header word of the granted source is g_data.
  - If g_data dest == PE_ADDR: pe_valid=req_valid[g], pe_data=g_data, req_ready[g]=pe_ready, pe_last=(LEN==0).
  - If dest differs: pe_valid=0, req_ready[g]=1. This is the drop path.
  - On the header transfer, load rem=LEN. Then:
    - LEN==0, forwarded: go to IDLE.
    - LEN==0, dropped: go to IDLE and increment drop_cnt.
    - LEN>0: go to FWD (forwarded) or DROP (dropped).
- State FWD:
  - Pass-through with no bubbles: pe_valid=req_valid[g], pe_data=req_data[g], req_ready[g]=pe_ready, pe_last=(rem==1).
  - Each transfer decrements rem.
  - The transfer with rem==1 moves to IDLE.
- State DROP:
  - req_ready[g]=1, pe_valid=0.
  - Each accepted word decrements rem.
  - The word with rem==1 moves to IDLE and increments drop_cnt. drop_cnt holds at all-ones and does not wrap.
- Non-granted sources: req_ready=0 always.
- Packet completion: set rr_ptr=(g+1) mod NREQ, applied in the same edge as the last-word transfer. Grant clears next cycle, so there is a minimum 1-cycle gap between packets.
- Stalls:
  - req_valid[g] low mid-packet: wait with no timeout; the grant is held.
  - pe_ready low: the granted source stalls; the scheduler does not drop.
- Simultaneous requests: round-robin from rr_ptr, so a source is served again only after every other active source has had one packet.
- Reset mid-packet: the packet is abandoned immediately and the PE may receive a truncated packet. Sources must also be reset.
- Busy signal: busy=1 in HDR, FWD and DROP; grant is nonzero exactly when busy=1.

Decomposition:
- Package pe_sched_pkg:
  - header field position/width localparams (DEST_HI/LO, SRC_HI/LO, TYPE_HI/LO, LEN_HI/LO);
  - typedef enum logic [1:0] {IDLE, HDR, FWD, DROP} sched_state_t;
  - function hdr_dest(), function hdr_len().
- One sub-module, rr_arbiter (NREQ param): inputs req and ptr, output one-hot grant. It is combinational, with a rotate, priority-pick and unrotate structure.

Test Plan:
- Single forward: PE_ADDR=001; source 0 sends 0x29000200, then 0x01010101, then 0x02020202, with pe_ready=1.
  - PE sees the 3 words on consecutive cycles; pe_last only on 0x02020202.
  - busy falls 1 cycle after the last word; drop_cnt=0.
- Drop: source 1 sends header 0x41000100 (dest=010, LEN=1) plus 1 payload word.
  - pe_valid stays 0 throughout; req_ready[1] is high for 2 cycles.
  - drop_cnt=1; next grant search starts at source 2.
- Contention: sources 0, 2 and 3 all hold 1-word-payload packets (0x29000100) from cycle 0.
  - Grant order is 0, 2, 3; no interleaving on the PE link.
  - After that, source 0 re-requests and is served after source 3.
- Backpressure: pe_ready toggles 1,0,0,1 during a LEN=3 forward.
  - Words are unchanged and in order; req_ready[g] mirrors pe_ready; no word is lost or duplicated.
- Zero-length: header 0x29000000 goes out with pe_last=1 in the same transfer; state returns to IDLE.
- Reset mid-packet: assert rst_n=0 asynchronously during FWD with rem=5.
  - Outputs go to their reset values immediately.
  - After release, a new packet from source 3 is granted in 1 cycle.

Source files
------------

// File: rtl/pe_sched_pkg.sv
// rtl/pe_sched_pkg.sv - header field layout, scheduler state type and header decode helpers
// Purpose: shared definitions for pe_ingress_scheduler and its bench.
// Ports: none (package).
package pe_sched_pkg;

  localparam int DEST_HI = 31;
  localparam int DEST_LO = 29;
  localparam int SRC_HI  = 28;
  localparam int SRC_LO  = 26;
  localparam int TYPE_HI = 25;
  localparam int TYPE_LO = 24;
  localparam int LEN_HI  = 15;
  localparam int LEN_LO  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    FWD  = 2'd2,
    DROP = 2'd3
  } sched_state_t;

  function automatic logic [DEST_HI-DEST_LO:0] hdr_dest(input logic [31:0] hdr);
    return hdr[DEST_HI:DEST_LO];
  endfunction

  function automatic logic [LEN_HI-LEN_LO:0] hdr_len(input logic [31:0] hdr);
    return hdr[LEN_HI:LEN_LO];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, first request at or above ptr
// Ports:
//   req   in  NREQ  request vector
//   ptr   in  PW    highest-priority index
//   grant out NREQ  one-hot winner, 0 when req is 0
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic [2*NREQ-1:0] dbl_req;
  logic [2*NREQ-1:0] dbl_pick;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   pick;
  logic              found;

  // Rotate so ptr lands on bit 0, take the lowest set bit, rotate back.
  always_comb begin
    dbl_req = {req, req} >> ptr;
    rot     = dbl_req[NREQ-1:0];
    pick    = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (rot[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    dbl_pick = {pick, pick} << ptr;
    grant    = dbl_pick[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/pe_ingress_scheduler.sv
// rtl/pe_ingress_scheduler.sv - round-robin packet scheduler feeding one PE ingress
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid/data/ready  NREQ source links, source i at req_data[i*WIDTH +: WIDTH]
//   pe_valid/data/last    word toward the PE, pe_ready from the PE
//   grant                 one-hot owner, 0 when idle
//   busy                  packet in progress
//   drop_cnt              saturating count of packets not addressed to PE_ADDR
module pe_ingress_scheduler
  import pe_sched_pkg::*;
#(
  parameter int         NREQ    = 4,
  parameter int         WIDTH   = 32,
  parameter logic [2:0] PE_ADDR = 3'b001,
  parameter int         DROP_CW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  pe_valid,
  output logic [WIDTH-1:0]      pe_data,
  output logic                  pe_last,
  input  logic                  pe_ready,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [DROP_CW-1:0]    drop_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_t    state, state_d;
  logic [NREQ-1:0] grant_q, grant_d, arb_grant;
  logic [PW-1:0]   rr_ptr, rr_ptr_d, g_idx, next_ptr;
  logic [7:0]      rem, rem_d, len;
  logic [WIDTH-1:0] g_data;
  logic            g_valid;
  logic            match, done, drop_inc;
  logic            fwd_valid, fwd_last, src_ready;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant)
  );

  // Granted source's word/valid and index; grant_q is one-hot so OR-muxing is exact.
  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        g_data  = g_data | req_data[i*WIDTH +: WIDTH];
        g_valid = g_valid | req_valid[i];
        g_idx   = PW'(i);
      end
    end
  end

  assign next_ptr = (g_idx == PW'(NREQ-1)) ? '0 : g_idx + 1'b1;
  assign match    = (hdr_dest(g_data[31:0]) == PE_ADDR);
  assign len      = hdr_len(g_data[31:0]);

  always_comb begin
    state_d   = state;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr;
    rem_d     = rem;
    done      = 1'b0;
    drop_inc  = 1'b0;
    fwd_valid = 1'b0;
    fwd_last  = 1'b0;
    src_ready = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_d = arb_grant;
          state_d = HDR;
        end
      end
      HDR: begin
        if (match) begin
          fwd_valid = g_valid;
          fwd_last  = (len == 8'd0);
          src_ready = pe_ready;
        end else begin
          src_ready = 1'b1;
        end
        if (g_valid && src_ready) begin
          rem_d = len;
          if (len == 8'd0) begin
            done     = 1'b1;
            drop_inc = !match;
          end else begin
            state_d = match ? FWD : DROP;
          end
        end
      end
      FWD: begin
        fwd_valid = g_valid;
        fwd_last  = (rem == 8'd1);
        src_ready = pe_ready;
        if (g_valid && pe_ready) begin
          rem_d = rem - 8'd1;
          done  = (rem == 8'd1);
        end
      end
      DROP: begin
        src_ready = 1'b1;
        if (g_valid) begin
          rem_d    = rem - 8'd1;
          done     = (rem == 8'd1);
          drop_inc = (rem == 8'd1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Completion releases the grant on the same edge as the last word.
    if (done) begin
      state_d  = IDLE;
      grant_d  = '0;
      rr_ptr_d = next_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_q  <= '0;
      rr_ptr   <= '0;
      rem      <= '0;
      drop_cnt <= '0;
    end else begin
      state   <= state_d;
      grant_q <= grant_d;
      rr_ptr  <= rr_ptr_d;
      rem     <= rem_d;
      if (drop_inc && (drop_cnt != {DROP_CW{1'b1}})) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  assign pe_valid  = fwd_valid;
  assign pe_data   = fwd_valid ? g_data : '0;
  assign pe_last   = fwd_valid & fwd_last;
  assign req_ready = src_ready ? grant_q : '0;
  assign grant     = grant_q;
  assign busy      = (state != IDLE);

endmodule
